// File: rtl/led_traffic_control_gen.sv
`timescale 1ns/1ps
// Main-road / country-road traffic light controller with a BCD countdown for the display.
// Night flash mode is compiled in only when FLASH_EN is defined.
module led_traffic_control_gen #(
   parameter int                  DIV_COEFF = 50_000_000,
   parameter int                  DIGITS    = 2,
   parameter logic [4*DIGITS-1:0] MG_TIME   = 'h60,
   parameter logic [4*DIGITS-1:0] MY_TIME   = 'h04,
   parameter logic [4*DIGITS-1:0] CG_TIME   = 'h20,
   parameter logic [4*DIGITS-1:0] CY_TIME   = 'h04,
   parameter logic [7:0]          CG_MIN    = 8'h05
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flag_s,
   input  logic                night_mode,
   output logic [4*DIGITS-1:0] num,
   output logic [5:0]          led,
   output logic [2:0]          phase,
   output logic                phase_chg,
   output logic                tick
);

   localparam int            CW       = (DIV_COEFF > 1) ? $clog2(DIV_COEFF) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DIV_COEFF - 1);
   localparam int            NW       = 4 * DIGITS;
   localparam logic [NW-1:0] BCD_ONE  = NW'(1);

   function automatic int bcd2bin(input logic [7:0] v);
      return int'(v[7:4]) * 10 + int'(v[3:0]);
   endfunction

   localparam logic [6:0] CG_MIN_B = 7'(bcd2bin(CG_MIN));

   typedef enum logic [2:0] {
      MGCR  = 3'd0,
      MYCR  = 3'd1,
      MRCG  = 3'd2,
      MRCY  = 3'd3,
      FLASH = 3'd4
   } phase_e;

   phase_e        phase_q, phase_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          tick_q, tick_d;
   logic [NW-1:0] num_q, num_d;
   logic [5:0]    led_q, led_d;
   logic          chg_q, chg_d;
   logic [6:0]    elapsed_q, elapsed_d;
   logic          last_sec;
   logic          flash_go;
`ifdef FLASH_EN
   logic          blink_q, blink_d;
`else
   logic          unused_night;
   assign unused_night = night_mode;
`endif

   // Ripple-borrow BCD decrement starting at the least significant digit.
   function automatic logic [NW-1:0] bcd_dec(input logic [NW-1:0] v);
      logic [NW-1:0] r;
      logic          borrow;
      r      = v;
      borrow = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (borrow) begin
            if (v[4*i +: 4] == 4'd0) begin
               r[4*i +: 4] = 4'd9;
            end else begin
               r[4*i +: 4] = v[4*i +: 4] - 4'd1;
               borrow      = 1'b0;
            end
         end
      end
      return r;
   endfunction

   function automatic logic [5:0] led_of(input phase_e p, input logic blink);
      case (p)
         MGCR:    return 6'b001100;
         MYCR:    return 6'b010100;
         MRCG:    return 6'b100001;
         MRCY:    return 6'b100010;
         FLASH:   return blink ? 6'b010010 : 6'b000000;
         default: return 6'b000000;
      endcase
   endfunction

   always_comb begin
      cnt_d     = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
      tick_d    = (cnt_q == CNT_LAST);
      phase_d   = phase_q;
      num_d     = num_q;
      elapsed_d = elapsed_q;
      last_sec  = (num_q == BCD_ONE);
`ifdef FLASH_EN
      blink_d   = blink_q;
      flash_go  = tick_q && night_mode;
`else
      flash_go  = 1'b0;
`endif
      if (flash_go) begin
         phase_d = FLASH;
         num_d   = '0;
`ifdef FLASH_EN
         blink_d = (phase_q == FLASH) ? ~blink_q : 1'b1;
`endif
      end else begin
         case (phase_q)
            MGCR: if (tick_q) begin
               if (!last_sec) begin
                  num_d = bcd_dec(num_q);
               end else if (flag_s) begin
                  phase_d = MYCR;
                  num_d   = MY_TIME;
               end else begin
                  num_d = MG_TIME;
               end
            end
            MYCR: if (tick_q) begin
               if (last_sec) begin
                  phase_d   = MRCG;
                  num_d     = CG_TIME;
                  elapsed_d = '0;
               end else begin
                  num_d = bcd_dec(num_q);
               end
            end
            MRCG: begin
               // Road emptied after the minimum green: leave without waiting for a tick.
               if (!flag_s && elapsed_q >= CG_MIN_B) begin
                  phase_d = MRCY;
                  num_d   = CY_TIME;
               end else if (tick_q) begin
                  if (elapsed_q < CG_MIN_B) elapsed_d = elapsed_q + 7'd1;
                  if (last_sec) begin
                     phase_d = MRCY;
                     num_d   = CY_TIME;
                  end else begin
                     num_d = bcd_dec(num_q);
                  end
               end
            end
            MRCY: if (tick_q) begin
               if (last_sec) begin
                  phase_d = MGCR;
                  num_d   = MG_TIME;
               end else begin
                  num_d = bcd_dec(num_q);
               end
            end
`ifdef FLASH_EN
            FLASH: if (tick_q) begin
               phase_d = MGCR;
               num_d   = MG_TIME;
            end
`endif
            default: begin
               phase_d = MGCR;
               num_d   = MG_TIME;
            end
         endcase
      end
      chg_d = (phase_d != phase_q);
`ifdef FLASH_EN
      led_d = led_of(phase_d, blink_d);
`else
      led_d = led_of(phase_d, 1'b0);
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q     <= '0;
         tick_q    <= 1'b0;
         phase_q   <= MGCR;
         num_q     <= MG_TIME;
         led_q     <= 6'b001100;
         chg_q     <= 1'b0;
         elapsed_q <= '0;
`ifdef FLASH_EN
         blink_q   <= 1'b0;
`endif
      end else begin
         cnt_q     <= cnt_d;
         tick_q    <= tick_d;
         phase_q   <= phase_d;
         num_q     <= num_d;
         led_q     <= led_d;
         chg_q     <= chg_d;
         elapsed_q <= elapsed_d;
`ifdef FLASH_EN
         blink_q   <= blink_d;
`endif
      end
   end

   assign num       = num_q;
   assign led       = led_q;
   assign phase     = phase_q;
   assign phase_chg = chg_q;
   assign tick      = tick_q;

endmodule

// File: tb/tb_led_traffic_control_gen.sv
`timescale 1ns/1ps
// Bench for led_traffic_control_gen: a seconds-based reference model predicts every cycle.
module tb_led_traffic_control_gen;
   localparam int DIV   = 4;
   localparam int MG    = 60;
   localparam int MY    = 4;
   localparam int CG    = 20;
   localparam int CY    = 4;
   localparam int CGMIN = 5;
   localparam int DIV3  = 2;
   localparam int MG3   = 100;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flag_s = 1'b0;
   logic        night_mode = 1'b0;
   logic        flag3 = 1'b0;
   logic        night3 = 1'b0;
   logic [7:0]  num;
   logic [5:0]  led;
   logic [2:0]  phase;
   logic        phase_chg, tick;
   logic [11:0] num3;
   logic [5:0]  led3;
   logic [2:0]  phase3;
   logic        chg3, tick3;

   int errors = 0;
   int checks = 0;

   // reference model state (seconds as plain integers)
   int m_cnt, m_phase, m_rem, m_el, m3_cnt, m3_rem;
   bit m_tick, m_blink, m_chg, m3_tick;
   logic [7:0]  e_num;
   logic [11:0] e_num3;
   logic [2:0]  e_phase;
   logic [5:0]  e_led;
   logic        e_tick, e_chg;

   always #5 clk = ~clk;

   led_traffic_control_gen #(
      .DIV_COEFF(DIV), .DIGITS(2), .MG_TIME(8'h60), .MY_TIME(8'h04),
      .CG_TIME(8'h20), .CY_TIME(8'h04), .CG_MIN(8'h05)
   ) u_dut (
      .clk(clk), .rst(rst), .flag_s(flag_s), .night_mode(night_mode),
      .num(num), .led(led), .phase(phase), .phase_chg(phase_chg), .tick(tick)
   );

   led_traffic_control_gen #(
      .DIV_COEFF(DIV3), .DIGITS(3), .MG_TIME(12'h100), .MY_TIME(12'h004),
      .CG_TIME(12'h020), .CY_TIME(12'h004), .CG_MIN(8'h05)
   ) u_dut3 (
      .clk(clk), .rst(rst), .flag_s(flag3), .night_mode(night3),
      .num(num3), .led(led3), .phase(phase3), .phase_chg(chg3), .tick(tick3)
   );

   function automatic logic [23:0] to_bcd(input int v);
      logic [23:0] r;
      int d;
      d = v;
      r = '0;
      for (int i = 0; i < 6; i++) begin
         r[4*i +: 4] = 4'(d % 10);
         d = d / 10;
      end
      return r;
   endfunction

   function automatic logic [5:0] exp_led(input int p, input bit b);
      case (p)
         0: return 6'b001100;
         1: return 6'b010100;
         2: return 6'b100001;
         3: return 6'b100010;
         4: return b ? 6'b010010 : 6'b000000;
         default: return 6'b000000;
      endcase
   endfunction

   always @(posedge clk) begin : model
      int np, nr, ne;
      bit nb;
      logic [23:0] b;
      if (rst) begin
         m_cnt = 0; m_tick = 0; m_phase = 0; m_rem = MG; m_el = 0; m_blink = 0; m_chg = 0;
         m3_cnt = 0; m3_tick = 0; m3_rem = MG3;
      end else begin
         np = m_phase; nr = m_rem; ne = m_el; nb = m_blink;
`ifdef FLASH_EN
         if (m_tick && night_mode) begin
            if (m_phase == 4) nb = !m_blink;
            else begin np = 4; nb = 1; end
            nr = 0;
         end else if (m_phase == 4) begin
            if (m_tick) begin np = 0; nr = MG; end
         end else
`endif
         if (m_phase == 2 && !flag_s && m_el >= CGMIN) begin
            np = 3; nr = CY;
         end else if (m_tick) begin
            if (m_phase == 2 && m_el < CGMIN) ne = m_el + 1;
            if (m_rem > 1) nr = m_rem - 1;
            else begin
               case (m_phase)
                  0: if (flag_s) begin np = 1; nr = MY; end else nr = MG;
                  1: begin np = 2; nr = CG; ne = 0; end
                  2: begin np = 3; nr = CY; end
                  default: begin np = 0; nr = MG; end
               endcase
            end
         end
         m_chg = (np != m_phase);
         m_phase = np; m_rem = nr; m_el = ne; m_blink = nb;
         m_tick = (m_cnt == DIV - 1);
         m_cnt = (m_cnt + 1) % DIV;
         if (m3_tick) m3_rem = (m3_rem == 1) ? MG3 : m3_rem - 1;
         m3_tick = (m3_cnt == DIV3 - 1);
         m3_cnt = (m3_cnt + 1) % DIV3;
      end
      b = to_bcd(m_rem);
      e_num = b[7:0];
      b = to_bcd(m3_rem);
      e_num3 = b[11:0];
      e_phase = 3'(m_phase);
      e_led = exp_led(m_phase, m_blink);
      e_tick = m_tick;
      e_chg = m_chg;
   end

   task automatic test_reset();
      rst = 1'b1; flag_s = 1'b0; night_mode = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (phase !== 3'd0) begin errors++; $display("FAIL reset_phase got %0d exp 0", phase); end
      checks++; if (num !== 8'h60) begin errors++; $display("FAIL reset_num got %h exp 60", num); end
      checks++; if (led !== 6'b001100) begin errors++; $display("FAIL reset_led got %b exp 001100", led); end
      checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b exp 0", tick); end
      checks++; if (phase_chg !== 1'b0) begin errors++; $display("FAIL reset_chg got %b exp 0", phase_chg); end
      checks++; if (u_dut.cnt_q !== '0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", u_dut.cnt_q); end
      checks++; if (num3 !== 12'h100) begin errors++; $display("FAIL reset_num3 got %h exp 100", num3); end
      rst = 1'b0;
      for (int c = 1; c <= DIV; c++) begin
         @(negedge clk);
         checks++;
         if (tick !== (c == DIV)) begin errors++; $display("FAIL first_tick c=%0d got %b exp %b", c, tick, (c == DIV)); end
      end
   endtask

   task automatic test_mg_hold();
      int chg_seen, ticks;
      chg_seen = 0; ticks = 0;
      flag_s = 1'b0;
      repeat (62 * DIV) begin
         @(negedge clk);
         checks++;
         if ({phase, num, led, tick, phase_chg} !== {e_phase, e_num, e_led, e_tick, e_chg}) begin
            errors++;
            $display("FAIL mg_hold t=%0t got ph=%0d num=%h led=%b tk=%b chg=%b exp ph=%0d num=%h led=%b tk=%b chg=%b",
                     $time, phase, num, led, tick, phase_chg, e_phase, e_num, e_led, e_tick, e_chg);
         end
         if (phase_chg) chg_seen++;
         if (tick) ticks++;
      end
      checks++; if (chg_seen !== 0) begin errors++; $display("FAIL mg_hold_chg got %0d exp 0", chg_seen); end
      checks++; if (ticks !== 62) begin errors++; $display("FAIL mg_hold_ticks got %0d exp 62", ticks); end
   endtask

   task automatic test_full_cycle();
      int run, idx;
      int durs [8];
      int exp_d [8] = '{MG, MY, CG, CY, MG, MY, CG, CY};
      run = 0; idx = 0;
      rst = 1'b1; flag_s = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (2 * (MG + MY + CG + CY) * DIV + 2) begin
         @(negedge clk);
         checks++;
         if ({phase, num, led, tick, phase_chg} !== {e_phase, e_num, e_led, e_tick, e_chg}) begin
            errors++;
            $display("FAIL full_cycle t=%0t got ph=%0d num=%h led=%b tk=%b chg=%b exp ph=%0d num=%h led=%b tk=%b chg=%b",
                     $time, phase, num, led, tick, phase_chg, e_phase, e_num, e_led, e_tick, e_chg);
         end
         if (phase_chg) begin
            if (idx < 8) durs[idx] = run;
            idx++;
            run = 0;
         end
         if (tick) run++;
      end
      checks++; if (idx !== 8) begin errors++; $display("FAIL full_cycle_chg_count got %0d exp 8", idx); end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (i < idx && durs[i] !== exp_d[i]) begin
            errors++; $display("FAIL phase_duration[%0d] got %0d exp %0d", i, durs[i], exp_d[i]);
         end
      end
   endtask

   task automatic test_early_exit();
      int n, n2, tk, t5, tx;
      logic [7:0] numx;
      n = 0; n2 = 0; tk = 0; t5 = -1; tx = -1; numx = '0;
      rst = 1'b1; flag_s = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      do begin
         @(negedge clk);
         n++;
         checks++;
         if ({phase, num, led, tick, phase_chg} !== {e_phase, e_num, e_led, e_tick, e_chg}) begin
            errors++;
            $display("FAIL early_wait t=%0t got ph=%0d num=%h exp ph=%0d num=%h", $time, phase, num, e_phase, e_num);
         end
      end while (phase !== 3'd2 && n < 400);
      checks++; if (phase !== 3'd2) begin errors++; $display("FAIL early_reach_mrcg got ph=%0d exp 2", phase); end
      while (phase === 3'd2 && n2 < 200) begin
         @(negedge clk);
         n2++;
         checks++;
         if ({phase, num, led, tick, phase_chg} !== {e_phase, e_num, e_led, e_tick, e_chg}) begin
            errors++;
            $display("FAIL early_exit t=%0t got ph=%0d num=%h led=%b chg=%b exp ph=%0d num=%h led=%b chg=%b",
                     $time, phase, num, led, phase_chg, e_phase, e_num, e_led, e_chg);
         end
         if (phase === 3'd2 && tick) begin
            tk++;
            if (tk == 2) flag_s = 1'b0;
            if (tk == 5) t5 = n2;
         end
         if (phase === 3'd3 && tx < 0) begin tx = n2; numx = num; end
      end
      checks++; if (tk !== CGMIN) begin errors++; $display("FAIL early_ticks got %0d exp %0d", tk, CGMIN); end
      checks++; if (tx - t5 !== 2) begin errors++; $display("FAIL early_latency got %0d exp 2", tx - t5); end
      checks++; if (numx !== 8'h04) begin errors++; $display("FAIL early_num got %h exp 04", numx); end
   endtask

   task automatic test_bcd3();
      bit saw_hi, saw_lo, saw_wrap;
      logic [11:0] prev;
      saw_hi = 0; saw_lo = 0; saw_wrap = 0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      prev = 12'h100;
      repeat (DIV3 * (MG3 + 2) + 2) begin
         @(negedge clk);
         checks++;
         if ({num3, phase3, chg3} !== {e_num3, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL bcd3 t=%0t got num=%h ph=%0d chg=%b exp num=%h ph=0 chg=0", $time, num3, phase3, chg3, e_num3);
         end
         if (prev == 12'h100 && num3 == 12'h099) saw_hi = 1;
         if (prev == 12'h010 && num3 == 12'h009) saw_lo = 1;
         if (prev == 12'h001 && num3 == 12'h100) saw_wrap = 1;
         prev = num3;
      end
      checks++; if (saw_hi !== 1'b1) begin errors++; $display("FAIL bcd3_100_to_099 got %b exp 1", saw_hi); end
      checks++; if (saw_lo !== 1'b1) begin errors++; $display("FAIL bcd3_010_to_009 got %b exp 1", saw_lo); end
      checks++; if (saw_wrap !== 1'b1) begin errors++; $display("FAIL bcd3_001_to_100 got %b exp 1", saw_wrap); end
   endtask

   task automatic test_reset_mid();
      int n;
      n = 0;
      flag_s = 1'b1;
      do begin
         @(negedge clk);
         n++;
         checks++;
         if ({phase, num, led, tick, phase_chg} !== {e_phase, e_num, e_led, e_tick, e_chg}) begin
            errors++;
            $display("FAIL mid_wait t=%0t got ph=%0d num=%h exp ph=%0d num=%h", $time, phase, num, e_phase, e_num);
         end
      end while (!(phase === 3'd1 && num === 8'h02) && n < 600);
      checks++; if (!(phase === 3'd1 && num === 8'h02)) begin errors++; $display("FAIL mid_reach got ph=%0d num=%h exp ph=1 num=02", phase, num); end
      rst = 1'b1;
      @(negedge clk);
      checks++; if (phase !== 3'd0) begin errors++; $display("FAIL mid_rst_phase got %0d exp 0", phase); end
      checks++; if (num !== 8'h60) begin errors++; $display("FAIL mid_rst_num got %h exp 60", num); end
      checks++; if (led !== 6'b001100) begin errors++; $display("FAIL mid_rst_led got %b exp 001100", led); end
      checks++; if (u_dut.cnt_q !== '0) begin errors++; $display("FAIL mid_rst_cnt got %0d exp 0", u_dut.cnt_q); end
      checks++; if (phase_chg !== 1'b0) begin errors++; $display("FAIL mid_rst_chg got %b exp 0", phase_chg); end
      rst = 1'b0;
   endtask

`ifdef FLASH_EN
   task automatic test_flash();
      int n;
      rst = 1'b1; flag_s = 1'b1; night_mode = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         checks++;
         if ({phase, num, led, tick, phase_chg} !== {e_phase, e_num, e_led, e_tick, e_chg}) begin
            errors++; $display("FAIL flash_wait t=%0t got ph=%0d num=%h exp ph=%0d num=%h", $time, phase, num, e_phase, e_num);
         end
      end while (phase !== 3'd2 && n < 400);
      night_mode = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         checks++;
         if ({phase, num, led, tick, phase_chg} !== {e_phase, e_num, e_led, e_tick, e_chg}) begin
            errors++; $display("FAIL flash_enter t=%0t got ph=%0d led=%b exp ph=%0d led=%b", $time, phase, led, e_phase, e_led);
         end
      end while (phase !== 3'd4 && n < 3 * DIV);
      checks++; if (led !== 6'b010010) begin errors++; $display("FAIL flash_first_led got %b exp 010010", led); end
      checks++; if (num !== 8'h00) begin errors++; $display("FAIL flash_num got %h exp 00", num); end
      repeat (5 * DIV) begin
         @(negedge clk);
         checks++;
         if ({phase, num, led, tick, phase_chg} !== {e_phase, e_num, e_led, e_tick, e_chg}) begin
            errors++; $display("FAIL flash_blink t=%0t got ph=%0d led=%b exp ph=%0d led=%b", $time, phase, led, e_phase, e_led);
         end
      end
      night_mode = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (phase !== 3'd0 && n < 3 * DIV);
      checks++; if (phase !== 3'd0) begin errors++; $display("FAIL flash_exit_phase got %0d exp 0", phase); end
      checks++; if (num !== 8'h60) begin errors++; $display("FAIL flash_exit_num got %h exp 60", num); end
   endtask
`endif

   task automatic test_random();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (3000) begin
         @(negedge clk);
         checks++;
         if ({phase, num, led, tick, phase_chg} !== {e_phase, e_num, e_led, e_tick, e_chg}) begin
            errors++;
            $display("FAIL random t=%0t got ph=%0d num=%h led=%b tk=%b chg=%b exp ph=%0d num=%h led=%b tk=%b chg=%b",
                     $time, phase, num, led, tick, phase_chg, e_phase, e_num, e_led, e_tick, e_chg);
         end
         if ($urandom_range(15) == 0) flag_s = ~flag_s;
         if ($urandom_range(299) == 0) night_mode = ~night_mode;
         rst = ($urandom_range(999) == 0);
      end
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_mg_hold();
      test_full_cycle();
      test_early_exit();
      test_bcd3();
      test_reset_mid();
`ifdef FLASH_EN
      test_flash();
`endif
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
